// File: rtl/reg_arb_pkg.sv
// Shared types and default constants for the register write arbiter.
package reg_arb_pkg;

  localparam int unsigned DEF_NREQ  = 2;
  localparam int unsigned DEF_NREGS = 4;
  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned MAX_NREQ  = 8;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  // Wide enough for the largest supported requester count, so one type serves every instance.
  typedef logic [$clog2(MAX_NREQ)-1:0] idx_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester/register-bank side signals of the write arbiter.
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned WIDTH = DEF_WIDTH
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       ack;
  logic [NREGS-1:0]      reg_load;
  logic [WIDTH-1:0]      reg_in;
  logic                  busy;

  modport master (
    output req, addr, wdata,
    input  ack, reg_load, reg_in, busy
  );

  modport slave (
    input  req, addr, wdata,
    output ack, reg_load, reg_in, busy
  );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin select: first requester after ptr (mod NREQ) wins.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0] req,
  input  idx_t            ptr,
  output logic            valid,
  output idx_t            idx
);

  int unsigned cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(ptr) + k) % NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!valid && (i == cand) && req[i]) begin
          valid = 1'b1;
          idx   = idx_t'(i);
        end
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the write port of a register bank between NREQ requesters.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic               clk,
  input logic               rst,
  reg_write_arbiter_if.slave bus
);

  localparam int unsigned AW = $clog2(NREGS);

  state_t           state, state_nxt;
  idx_t             ptr, win, pick_idx;
  logic             pick_valid;
  logic [AW-1:0]    laddr, sel_addr;
  logic [WIDTH-1:0] ldata, sel_data;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == idx_t'(i)) begin
        sel_addr = bus.addr[i*AW +: AW];
        sel_data = bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= idx_t'(NREQ - 1);
      win   <= '0;
      laddr <= '0;
      ldata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_valid) begin
        win   <= pick_idx;
        ptr   <= pick_idx;
        laddr <= sel_addr;
        ldata <= sel_data;
      end
    end
  end

  // Outputs depend only on state and latched values, so live addr changes never reach reg_load.
  always_comb begin
    state_nxt    = state;
    bus.ack      = '0;
    bus.reg_load = '0;
    bus.reg_in   = '0;
    bus.busy     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt           = IDLE;
        bus.reg_load[laddr] = 1'b1;
        bus.reg_in          = ldata;
        bus.busy            = 1'b1;
        for (int unsigned i = 0; i < NREQ; i++) begin
          bus.ack[i] = (win == idx_t'(i));
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural register bank on its outputs.
module tb_reg_write_arbiter;
    import reg_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    reg_write_arbiter_if #(.NREQ(2), .NREGS(4), .WIDTH(16)) bus ();

    reg_write_arbiter #(.NREQ(2), .NREGS(4), .WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // REGISTER cells: rising-edge load, no reset.
    logic [15:0] regs [4];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bus.reg_load[i]) regs[i] <= bus.reg_in;
    end

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  a0, a1;
        logic [15:0] d0, d1;
        logic [1:0]  ack;
        logic [3:0]  load;
        logic [15:0] rin;
        logic        busy;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic [1:0] ack, input logic [3:0] load,
                              input logic [15:0] rin, input logic busy);
        check({name, ".ack"},  32'(bus.ack), 32'(ack));
        check({name, ".load"}, 32'(bus.reg_load), 32'(load));
        check({name, ".rin"},  32'(bus.reg_in), 32'(rin));
        check({name, ".busy"}, 32'(bus.busy), 32'(busy));
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] a0, input logic [1:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1);
        bus.req   = req;
        bus.addr  = {a1, a0};
        bus.wdata = {d1, d0};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with requests pending, single writes, alternating contention, persistent requester
        vecs[0]  = '{1'b1, 2'b11, 2'd1, 2'd2, 16'hAAAA, 16'hBBBB, 2'b00, 4'b0000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 2'b11, 2'd1, 2'd2, 16'hAAAA, 16'hBBBB, 2'b00, 4'b0000, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 2'b11, 2'd2, 2'd3, 16'h00A5, 16'h0B0B, 2'b01, 4'b0100, 16'h00A5, 1'b1};
        vecs[3]  = '{1'b0, 2'b10, 2'd2, 2'd3, 16'h00A5, 16'h0B0B, 2'b00, 4'b0000, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 2'b11, 2'd2, 2'd3, 16'h00A5, 16'h0B0B, 2'b10, 4'b1000, 16'h0B0B, 1'b1};
        vecs[5]  = '{1'b0, 2'b01, 2'd2, 2'd3, 16'h00A5, 16'h0B0B, 2'b00, 4'b0000, 16'h0000, 1'b0};
        vecs[6]  = '{1'b0, 2'b11, 2'd2, 2'd3, 16'h00A5, 16'h0B0B, 2'b01, 4'b0100, 16'h00A5, 1'b1};
        vecs[7]  = '{1'b0, 2'b10, 2'd2, 2'd3, 16'h00A5, 16'h0B0B, 2'b00, 4'b0000, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 2'b11, 2'd2, 2'd3, 16'h00A5, 16'h0B0B, 2'b10, 4'b1000, 16'h0B0B, 1'b1};
        vecs[9]  = '{1'b0, 2'b00, 2'd2, 2'd3, 16'h00A5, 16'h0B0B, 2'b00, 4'b0000, 16'h0000, 1'b0};
        vecs[10] = '{1'b0, 2'b00, 2'd2, 2'd3, 16'h00A5, 16'h0B0B, 2'b00, 4'b0000, 16'h0000, 1'b0};
        vecs[11] = '{1'b0, 2'b01, 2'd1, 2'd3, 16'h1234, 16'h0B0B, 2'b01, 4'b0010, 16'h1234, 1'b1};
        vecs[12] = '{1'b0, 2'b01, 2'd1, 2'd3, 16'h1234, 16'h0B0B, 2'b00, 4'b0000, 16'h0000, 1'b0};
        vecs[13] = '{1'b0, 2'b01, 2'd1, 2'd3, 16'h1234, 16'h0B0B, 2'b01, 4'b0010, 16'h1234, 1'b1};
        vecs[14] = '{1'b0, 2'b00, 2'd1, 2'd3, 16'h1234, 16'h0B0B, 2'b00, 4'b0000, 16'h0000, 1'b0};

        drive(2'b11, 2'd1, 2'd2, 16'hAAAA, 16'hBBBB);
        for (int i = 0; i < 15; i++) begin
            rst = vecs[i].rst;
            drive(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            tick();
            expect_out($sformatf("vec%0d", i), vecs[i].ack, vecs[i].load, vecs[i].rin, vecs[i].busy);
        end
        check("bank.r2", 32'(regs[2]), 32'h00A5);
        check("bank.r3", 32'(regs[3]), 32'h0B0B);
        check("bank.r1", 32'(regs[1]), 32'h1234);

        // same-register conflict; live addr/data changes during WRITE must not leak through
        rst = 1'b1; drive(2'b00, 2'd0, 2'd0, 16'h0, 16'h0); tick();
        rst = 1'b0; drive(2'b11, 2'd1, 2'd1, 16'h1111, 16'h2222); tick();
        expect_out("conf.g0", 2'b01, 4'b0010, 16'h1111, 1'b1);
        drive(2'b11, 2'd3, 2'd1, 16'hFFFF, 16'h2222); #1;
        expect_out("conf.hold", 2'b01, 4'b0010, 16'h1111, 1'b1);
        drive(2'b10, 2'd1, 2'd1, 16'h1111, 16'h2222); tick();
        expect_out("conf.idle", 2'b00, 4'b0000, 16'h0000, 1'b0);
        check("conf.r1a", 32'(regs[1]), 32'h1111);
        tick();
        expect_out("conf.g1", 2'b10, 4'b0010, 16'h2222, 1'b1);
        drive(2'b00, 2'd1, 2'd1, 16'h1111, 16'h2222); tick();
        check("conf.r1b", 32'(regs[1]), 32'h2222);

        // requester 1 holds req one cycle past its ack and is re-granted after requester 0
        rst = 1'b1; tick();
        rst = 1'b0; drive(2'b11, 2'd0, 2'd3, 16'h0101, 16'h0303); tick();
        expect_out("late.g0a", 2'b01, 4'b0001, 16'h0101, 1'b1);
        bus.req = 2'b10; tick();
        expect_out("late.i0", 2'b00, 4'b0000, 16'h0000, 1'b0);
        tick();
        expect_out("late.g1a", 2'b10, 4'b1000, 16'h0303, 1'b1);
        bus.req = 2'b11; tick();
        expect_out("late.i1", 2'b00, 4'b0000, 16'h0000, 1'b0);
        tick();
        expect_out("late.g0b", 2'b01, 4'b0001, 16'h0101, 1'b1);
        bus.req = 2'b10; tick();
        expect_out("late.i2", 2'b00, 4'b0000, 16'h0000, 1'b0);
        tick();
        expect_out("late.g1b", 2'b10, 4'b1000, 16'h0303, 1'b1);
        bus.req = 2'b00; tick();
        expect_out("late.i3", 2'b00, 4'b0000, 16'h0000, 1'b0);

        // reset asserted in a WRITE cycle: the write lands, pointer returns to NREQ-1
        rst = 1'b1; tick();
        rst = 1'b0; drive(2'b01, 2'd3, 2'd0, 16'hBEEF, 16'h5555); tick();
        expect_out("rstw.g0", 2'b01, 4'b1000, 16'hBEEF, 1'b1);
        rst = 1'b1; bus.req = 2'b10; tick();
        expect_out("rstw.r0", 2'b00, 4'b0000, 16'h0000, 1'b0);
        check("rstw.r3", 32'(regs[3]), 32'hBEEF);
        tick();
        expect_out("rstw.r1", 2'b00, 4'b0000, 16'h0000, 1'b0);
        rst = 1'b0; bus.req = 2'b11; tick();
        expect_out("rstw.g0b", 2'b01, 4'b1000, 16'hBEEF, 1'b1);
        bus.req = 2'b10; tick();
        expect_out("rstw.i0", 2'b00, 4'b0000, 16'h0000, 1'b0);
        tick();
        expect_out("rstw.g1", 2'b10, 4'b0001, 16'h5555, 1'b1);
        bus.req = 2'b00; tick();
        check("rstw.r0v", 32'(regs[0]), 32'h5555);
        expect_out("rstw.end", 2'b00, 4'b0000, 16'h0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
